// File: rtl/key_led_ctrl.sv
// Debounced push-button mode controller: OFF -> ON -> SLOW blink -> FAST blink.
// Optional long-press-to-OFF is enabled by defining KEY_LED_LONGPRESS_EN.
module key_led_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SLOW_DIV        = 25_000_000,
    parameter int FAST_DIV        = 6_250_000,
    parameter int LONG_CYCLES     = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key,
    output logic       led,
    output logic [1:0] mode,
    output logic       press_pulse
);

    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DIV_MAX = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int BL_W    = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BL_W-1:0] SLOW_LAST = BL_W'(SLOW_DIV - 1);
    localparam logic [BL_W-1:0] FAST_LAST = BL_W'(FAST_DIV - 1);

    typedef enum logic [1:0] {
        M_OFF  = 2'd0,
        M_ON   = 2'd1,
        M_SLOW = 2'd2,
        M_FAST = 2'd3
    } mode_t;

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            pulse_q, pulse_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    mode_t           mode_q;
    logic [BL_W-1:0] pre_q;
    logic [BL_W-1:0] div_last;
    logic            phase_q;
    logic            led_q;
    logic            long_fire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key;
            sync2_q <= sync1_q;
        end
    end

    // Any cycle where the synchronized key agrees with the accepted level restarts the count.
    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
        pulse_d = level_q & ~level_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q  <= 1'b1;
            db_cnt_q <= '0;
            pulse_q  <= 1'b0;
        end else begin
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
            pulse_q  <= pulse_d;
        end
    end

`ifdef KEY_LED_LONGPRESS_EN
    localparam int LG_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [LG_W-1:0] LONG_LAST = LG_W'(LONG_CYCLES - 1);

    logic [LG_W-1:0] hold_q;
    logic            hold_done_q;

    // hold_done_q keeps a long hold from firing more than once before release.
    assign long_fire = ~level_q & ~hold_done_q & (hold_q == LONG_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || level_q) begin
            hold_q      <= '0;
            hold_done_q <= 1'b0;
        end else if (long_fire) begin
            hold_done_q <= 1'b1;
        end else if (hold_q != LONG_LAST) begin
            hold_q <= hold_q + LG_W'(1);
        end
    end
`else
    logic unused_long_cfg;
    assign unused_long_cfg = (LONG_CYCLES > 0);
    assign long_fire       = 1'b0;
`endif

    always_comb begin
        div_last = (mode_q == M_SLOW) ? SLOW_LAST : FAST_LAST;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q  <= M_OFF;
            pre_q   <= '0;
            phase_q <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            if (long_fire && mode_q != M_OFF) begin
                mode_q  <= M_OFF;
                pre_q   <= '0;
                phase_q <= 1'b1;
            end else if (pulse_q) begin
                mode_q  <= mode_t'(mode_q + 2'd1);
                pre_q   <= '0;
                phase_q <= 1'b1;
            end else if (mode_q == M_SLOW || mode_q == M_FAST) begin
                if (pre_q == div_last) begin
                    pre_q   <= '0;
                    phase_q <= ~phase_q;
                end else begin
                    pre_q <= pre_q + BL_W'(1);
                end
            end else begin
                pre_q   <= '0;
                phase_q <= 1'b0;
            end

            case (mode_q)
                M_OFF:   led_q <= 1'b0;
                M_ON:    led_q <= 1'b1;
                default: led_q <= phase_q;
            endcase
        end
    end

    assign led         = led_q;
    assign mode        = mode_q;
    assign press_pulse = pulse_q;

endmodule

// File: tb/tb_key_led_ctrl.sv
// Directed + randomized bench for key_led_ctrl against a cycle-level behavioural model.
module tb_key_led_ctrl;

    localparam int DB   = 4;
    localparam int SLOW = 8;
    localparam int FAST = 2;
    localparam int LONG = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key;
    logic       led;
    logic [1:0] mode;
    logic       press_pulse;

    int vectors    = 0;
    int miscompares = 0;

    key_led_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .SLOW_DIV       (SLOW),
        .FAST_DIV       (FAST),
        .LONG_CYCLES    (LONG)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key        (key),
        .led        (led),
        .mode       (mode),
        .press_pulse(press_pulse)
    );

    always #5 clk = ~clk;

    // Reference model state: key delay line, debounce run length, low-hold run,
    // mode as an integer, and the edge at which the current mode was entered.
    int m_cyc = 0;
    int m_kq[2];
    int m_level, m_pulse, m_mode, m_led, m_phase;
    int m_diff_run, m_low_run, m_entry;

    task automatic model_edge(input int k, input int r);
        int pre_mode, pre_phase, pre_level, pre_pulse, synced, fire, div;
        m_cyc++;
        if (r != 0) begin
            m_kq[0] = 1; m_kq[1] = 1;
            m_level = 1; m_pulse = 0; m_mode = 0; m_led = 0; m_phase = 0;
            m_diff_run = 0; m_low_run = 0; m_entry = m_cyc;
            return;
        end
        pre_mode  = m_mode;
        pre_phase = m_phase;
        pre_level = m_level;
        pre_pulse = m_pulse;
        m_led = (pre_mode == 0) ? 0 : (pre_mode == 1) ? 1 : pre_phase;

        synced  = m_kq[0];
        m_kq[0] = m_kq[1];
        m_kq[1] = k;

        if (synced != pre_level) begin
            m_diff_run++;
            if (m_diff_run == DB) begin
                m_level    = synced;
                m_diff_run = 0;
            end
        end else begin
            m_diff_run = 0;
        end
        m_pulse = (pre_level == 1 && m_level == 0) ? 1 : 0;

        fire = 0;
        if (pre_level == 0) begin
            m_low_run++;
`ifdef KEY_LED_LONGPRESS_EN
            if (m_low_run == LONG) fire = 1;
`endif
        end else begin
            m_low_run = 0;
        end

        if (fire != 0 && pre_mode != 0) begin
            m_mode  = 0;
            m_entry = m_cyc;
        end else if (pre_pulse != 0) begin
            m_mode  = (pre_mode + 1) % 4;
            m_entry = m_cyc;
        end

        if (m_mode >= 2) begin
            div     = (m_mode == 2) ? SLOW : FAST;
            m_phase = (((m_cyc - m_entry) / div) % 2 == 0) ? 1 : 0;
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @%0d observed=%0h expected=%0h", tag, m_cyc, obs, exp);
        end
    endtask

    task automatic tick(input int k, input int r);
        key   = (k != 0);
        rst_n = (r == 0);
        @(posedge clk);
        model_edge(k, r);
        #1;
        chk("mode",  {30'b0, mode},        32'(m_mode));
        chk("led",   {31'b0, led},         32'(m_led));
        chk("pulse", {31'b0, press_pulse}, 32'(m_pulse));
    endtask

    task automatic press(input int low_len, input int high_len, output int lat, output int np);
        lat = -1;
        np  = 0;
        for (int i = 0; i < low_len; i++) begin
            tick(0, 0);
            if (press_pulse === 1'b1) begin
                np++;
                if (lat < 0) lat = i + 1;
            end
        end
        for (int i = 0; i < high_len; i++) begin
            tick(1, 0);
            if (press_pulse === 1'b1) np++;
        end
    endtask

    initial begin
        int lat, np, lvl, len, sel;
        int wrap_exp[4];
        wrap_exp = '{1, 2, 3, 0};
        m_kq[0] = 1; m_kq[1] = 1;
        m_level = 1; m_pulse = 0; m_mode = 0; m_led = 0; m_phase = 0;
        m_diff_run = 0; m_low_run = 0; m_entry = 0;
        key   = 1'b1;
        rst_n = 1'b0;

        repeat (3) tick(1, 1);
        chk("rst_mode",  {30'b0, mode},        32'd0);
        chk("rst_led",   {31'b0, led},         32'd0);
        chk("rst_pulse", {31'b0, press_pulse}, 32'd0);
        repeat (5) tick(1, 0);

        // Bounce shorter than the debounce window.
        press(3, 10, lat, np);
        chk("bounce_np",   32'(np),        32'd0);
        chk("bounce_mode", {30'b0, mode},  32'd0);
        chk("bounce_led",  {31'b0, led},   32'd0);

        // Clean press: OFF -> ON.
        press(12, 12, lat, np);
        chk("press_lat",  32'(lat),       32'd6);
        chk("press_np",   32'(np),        32'd1);
        chk("press_mode", {30'b0, mode},  32'd1);
        chk("press_led",  {31'b0, led},   32'd1);

        // ON -> SLOW, observe blinking, then SLOW -> FAST.
        press(12, 40, lat, np);
        chk("slow_mode", {30'b0, mode}, 32'd2);
        press(12, 20, lat, np);
        chk("fast_mode", {30'b0, mode}, 32'd3);

        // Reset mid-blink.
        tick(1, 1);
        chk("rstblink_mode",  {30'b0, mode},        32'd0);
        chk("rstblink_led",   {31'b0, led},         32'd0);
        chk("rstblink_pulse", {31'b0, press_pulse}, 32'd0);
        repeat (3) tick(1, 0);

        // Long hold from OFF.
        press(40, 12, lat, np);
        chk("long_lat", 32'(lat), 32'd6);
        chk("long_np",  32'(np),  32'd1);
`ifdef KEY_LED_LONGPRESS_EN
        chk("long_mode", {30'b0, mode}, 32'd0);
`else
        chk("long_mode", {30'b0, mode}, 32'd1);
`endif

        // Four presses from OFF wrap back to OFF.
        tick(1, 1);
        repeat (3) tick(1, 0);
        for (int i = 0; i < 4; i++) begin
            press(12, 10, lat, np);
            chk("wrap_np",   32'(np),       32'd1);
            chk("wrap_mode", {30'b0, mode}, 32'(wrap_exp[i]));
        end
        chk("wrap_led", {31'b0, led}, 32'd0);

        // Randomized key activity with occasional resets.
        lvl = 1;
        for (int seg = 0; seg < 150; seg++) begin
            sel = int'($urandom_range(0, 39));
            if (sel == 0) begin
                tick(lvl, 1);
            end else if (sel < 15) begin
                len = int'($urandom_range(1, DB - 1));
                repeat (len) tick(1 - lvl, 0);
            end else begin
                lvl = int'($urandom_range(0, 1));
                len = int'($urandom_range(4, 45));
                repeat (len) tick(lvl, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
